// File: rtl/joy_level_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : joy_level_ctrl                                                |
// | Description : Conditions the raw hps_io joystick_0 word into a wrapping     |
// |               layer brightness level. The increment and decrement buttons   |
// |               are synchronised, debounced and edge-detected. Each press     |
// |               steps the registered level by one.                            |
// | Macro       : AUTOREPEAT_EN - adds a per-button hold-to-repeat FSM          |
// | Ports       : clk           - system clock (clk_sys)                        |
// |               reset_n       - asynchronous active-low reset                 |
// |               joy[31:0]     - raw joystick_0 word, asynchronous to clk      |
// |               layer_1_level - current level, 0..MAX_LEVEL                   |
// |               level_changed - one-cycle pulse when the level takes a new    |
// |                               value                                         |
// |               btn_press[1:0]- one-cycle press/repeat pulses, [0]=inc        |
// |                               [1]=dec                                       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module joy_level_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int unsigned MAX_LEVEL       = 10,
    parameter int unsigned RESET_LEVEL     = 10,
    parameter int unsigned INC_BIT         = 4,
    parameter int unsigned DEC_BIT         = 5,
    parameter logic [23:0] REPEAT_DELAY    = 24'd6000000,
    parameter logic [23:0] REPEAT_RATE     = 24'd1500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] joy,
    output logic [3:0]  layer_1_level,
    output logic        level_changed,
    output logic [1:0]  btn_press
);

    localparam int unsigned c_DB      = 32'(DEBOUNCE_CYCLES);
    localparam int unsigned c_DB_W    = $clog2(c_DB + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(c_DB);
    localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);
    localparam logic [3:0]  c_MAX     = 4'(MAX_LEVEL);
    localparam logic [3:0]  c_RESET   = 4'(RESET_LEVEL);

`ifdef AUTOREPEAT_EN
    localparam int unsigned c_RD      = 32'(REPEAT_DELAY);
    localparam int unsigned c_RR      = 32'(REPEAT_RATE);
    localparam int unsigned c_REP_MAX = (c_RD > c_RR) ? c_RD : c_RR;
    localparam int unsigned c_REP_W   = $clog2(c_REP_MAX + 1);
    localparam logic [c_REP_W-1:0] c_RD_LAST  = c_REP_W'(c_RD - 1);
    localparam logic [c_REP_W-1:0] c_RR_LAST  = c_REP_W'(c_RR - 1);
    localparam logic [c_REP_W-1:0] c_REP_ONE  = c_REP_W'(1);
    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_DELAY  = 2'd1;
    localparam logic [1:0] c_S_REPEAT = 2'd2;
`else
    localparam int unsigned c_unused_repeat = 32'(REPEAT_DELAY) + 32'(REPEAT_RATE);
`endif

    // Only the two button bits are consumed.
    logic w_unused_joy;
    assign w_unused_joy = ^joy;

    for (genvar i = 0; i < 2; i++) begin : g_btn
        localparam logic [4:0] c_IDX = (i == 0) ? 5'(INC_BIT) : 5'(DEC_BIT);

        logic [1:0]        r_sync;
        logic              r_stable;
        logic              r_stable_d;
        logic [c_DB_W-1:0] r_db_cnt;
        logic              r_press;
        logic              w_rise;
        logic              w_rep;

        assign w_rise       = r_stable & ~r_stable_d;
        assign btn_press[i] = r_press;

        // The counter has to reach DEBOUNCE_CYCLES and then see one more
        // differing sample before the stable state flips.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sync     <= 2'b00;
                r_stable   <= 1'b0;
                r_stable_d <= 1'b0;
                r_db_cnt   <= '0;
                r_press    <= 1'b0;
            end else begin
                r_sync     <= {r_sync[0], joy[c_IDX]};
                r_stable_d <= r_stable;
                if (r_sync[1] == r_stable) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == c_DB_LAST) begin
                    r_stable <= ~r_stable;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_ONE;
                end
                r_press <= w_rise | w_rep;
            end
        end

`ifdef AUTOREPEAT_EN
        logic [1:0]         r_state;
        logic [c_REP_W-1:0] r_rep_cnt;

        // Repeat is decided combinationally so it registers into r_press on
        // the same edge that the FSM restarts its counter.
        assign w_rep = r_stable &&
                       (((r_state == c_S_DELAY)  && (r_rep_cnt == c_RD_LAST)) ||
                        ((r_state == c_S_REPEAT) && (r_rep_cnt == c_RR_LAST)));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state   <= c_S_IDLE;
                r_rep_cnt <= '0;
            end else if (!r_stable) begin
                r_state   <= c_S_IDLE;
                r_rep_cnt <= '0;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        if (w_rise) begin
                            r_state   <= c_S_DELAY;
                            r_rep_cnt <= '0;
                        end
                    end
                    c_S_DELAY: begin
                        if (r_rep_cnt == c_RD_LAST) begin
                            r_state   <= c_S_REPEAT;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + c_REP_ONE;
                        end
                    end
                    c_S_REPEAT: begin
                        if (r_rep_cnt == c_RR_LAST) begin
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + c_REP_ONE;
                        end
                    end
                    default: begin
                        r_state   <= c_S_IDLE;
                        r_rep_cnt <= '0;
                    end
                endcase
            end
        end
`else
        assign w_rep = 1'b0;
`endif
    end

    logic [3:0] r_level;
    logic       r_changed;
    logic [3:0] w_level_next;

    // Any out-of-range level is pulled back into range by the next step.
    always_comb begin
        w_level_next = r_level;
        case (btn_press)
            2'b01:   w_level_next = (r_level >= c_MAX) ? 4'd0 : r_level + 4'd1;
            2'b10:   w_level_next = ((r_level == 4'd0) || (r_level > c_MAX)) ? c_MAX : r_level - 4'd1;
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level   <= c_RESET;
            r_changed <= 1'b0;
        end else begin
            r_level   <= w_level_next;
            r_changed <= (w_level_next != r_level);
        end
    end

    assign layer_1_level = r_level;
    assign level_changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_joy_level_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_joy_level_ctrl                                             |
// | Description : Directed bench for joy_level_ctrl. Expected press pulses and  |
// |               level updates are queued when stimulus is driven and matched  |
// |               against DUT activity at each falling clock edge.              |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_joy_level_ctrl;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } ev_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] joy;
    logic [3:0]  layer_1_level;
    logic        level_changed;
    logic [1:0]  btn_press;

    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    logic [3:0]  exp_level;
    ev_t         pq[$];
    ev_t         lq[$];

    joy_level_ctrl #(
        .DEBOUNCE_CYCLES (16'd4),
        .MAX_LEVEL       (10),
        .RESET_LEVEL     (10),
        .INC_BIT         (4),
        .DEC_BIT         (5),
        .REPEAT_DELAY    (24'd20),
        .REPEAT_RATE     (24'd8)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .joy           (joy),
        .layer_1_level (layer_1_level),
        .level_changed (level_changed),
        .btn_press     (btn_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [3:0] model_step(input logic [3:0] l, input logic [1:0] b);
        case (b)
            2'b01:   return (l >= 4'd10) ? 4'd0 : l + 4'd1;
            2'b10:   return ((l == 4'd0) || (l > 4'd10)) ? 4'd10 : l - 4'd1;
            default: return l;
        endcase
    endfunction

    // Scoreboard: every nonzero btn_press / level_changed must match the
    // queue head scheduled for this cycle, and every scheduled event must show.
    always @(negedge clk) begin
        logic [1:0] ep;
        logic       ec;
        logic [3:0] el;
        ev_t        e;
        if (mon_en) begin
            ep = 2'b00;
            ec = 1'b0;
            el = layer_1_level;
            if (pq.size() != 0 && pq[0].cyc == cyc) begin
                e  = pq.pop_front();
                ep = e.val[1:0];
            end
            if (lq.size() != 0 && lq[0].cyc == cyc) begin
                e  = lq.pop_front();
                ec = 1'b1;
                el = e.val;
            end
            if (btn_press !== 2'b00 || ep != 2'b00)
                check($sformatf("btn_press@%0d", cyc), 32'(btn_press), 32'(ep));
            if (level_changed !== 1'b0 || ec) begin
                check($sformatf("level_changed@%0d", cyc), 32'(level_changed), 32'(ec));
                check($sformatf("level@%0d", cyc), 32'(layer_1_level), 32'(el));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_press(input int pc, input logic [1:0] b);
        ev_t        e;
        logic [3:0] nl;
        e.cyc = pc;
        e.val = {2'b00, b};
        pq.push_back(e);
        nl = model_step(exp_level, b);
        if (nl != exp_level) begin
            e.cyc = pc + 1;
            e.val = nl;
            lq.push_back(e);
        end
        exp_level = nl;
    endtask

    // Raise the selected buttons for 'hold' cycles; press pulse due at E+7.
    task automatic press(input logic [1:0] b, input int hold);
        joy[4] = b[0];
        joy[5] = b[1];
        push_press(cyc + 1 + 7, b);
        tick(hold);
        joy[4] = 1'b0;
        joy[5] = 1'b0;
        tick(14);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        joy     = 32'h0;
        tick(3);
        reset_n   = 1'b1;
        exp_level = 4'd10;
        tick(2);
    endtask

    initial begin
        int p;
        reset_n   = 1'b0;
        joy       = 32'hFFFF_FFFF;
        exp_level = 4'd10;
        tick(5);

        // Reset state
        check("rst_level", 32'(layer_1_level), 32'd10);
        check("rst_changed", 32'(level_changed), 32'd0);
        check("rst_press", 32'(btn_press), 32'd0);
        joy     = 32'h0;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check("idle_level", 32'(layer_1_level), 32'd10);
            check("idle_changed", 32'(level_changed), 32'd0);
            check("idle_press", 32'(btn_press), 32'd0);
        end

        // Clean inc press wraps 10 -> 0
        press(2'b01, 10);
        check("inc_wrap", 32'(layer_1_level), 32'd0);

        // Dec wraps 0 -> 10
        press(2'b10, 10);
        check("dec_wrap", 32'(layer_1_level), 32'd10);

        // Bounce shorter than the debounce window is ignored
        for (int i = 0; i < 5; i++) begin
            joy[4] = 1'b1;
            tick(3);
            joy[4] = 1'b0;
            tick(2);
        end
        tick(10);
        check("bounce_level", 32'(layer_1_level), 32'd10);
        press(2'b01, 6);
        check("pulse6_level", 32'(layer_1_level), 32'd0);

        // Step up to 5, then dec to 4 and 3
        for (int i = 0; i < 5; i++) press(2'b01, 10);
        check("inc_to5", 32'(layer_1_level), 32'd5);
        press(2'b10, 10);
        check("dec_5to4", 32'(layer_1_level), 32'd4);
        press(2'b10, 10);
        check("dec_4to3", 32'(layer_1_level), 32'd3);

        // Simultaneous inc+dec: both pulses, no level change
        press(2'b11, 10);
        check("both_level", 32'(layer_1_level), 32'd3);

        // Long hold from level 0
        do_reset();
        press(2'b01, 10);
        check("pre_hold", 32'(layer_1_level), 32'd0);
        joy[4] = 1'b1;
        p = cyc + 1 + 7;
        push_press(p, 2'b01);
`ifdef AUTOREPEAT_EN
        for (int k = 0; k < 5; k++) push_press(p + 20 + 8 * k, 2'b01);
`endif
        tick(p + 52 - cyc);
        joy[4] = 1'b0;
        tick(20);
`ifdef AUTOREPEAT_EN
        check("hold_level", 32'(layer_1_level), 32'd6);
`else
        check("hold_level", 32'(layer_1_level), 32'd1);
`endif

        // Reset in the middle of a hold discards the event in progress
        do_reset();
        press(2'b01, 10);
        joy[4] = 1'b1;
        p = cyc + 1 + 7;
        push_press(p, 2'b01);
`ifdef AUTOREPEAT_EN
        push_press(p + 20, 2'b01);
        push_press(p + 28, 2'b01);
`endif
        tick(p + 30 - cyc);
        reset_n = 1'b0;
        joy     = 32'h0;
        #1;
        check("midrst_level", 32'(layer_1_level), 32'd10);
        check("midrst_press", 32'(btn_press), 32'd0);
        tick(3);
        reset_n   = 1'b1;
        exp_level = 4'd10;
        tick(80);
        check("postrst_level", 32'(layer_1_level), 32'd10);

        check("press_queue_empty", 32'(pq.size()), 32'd0);
        check("level_queue_empty", 32'(lq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
